// File: rtl/rate_sel_timebase.sv
// rate_sel_timebase
//
// Runtime-selectable data-rate timebase for the array driver, running in the
// 48 MHz command clock domain. The command clock is divided by 2^d, where d is
// chosen over the USB command path. The divided rate drives the carrier-period
// and phase-step counters. Their lengths are the d=0 base lengths shifted right
// by d, so one carrier period always spans BASE_PERIOD_CYCLES clocks.
//
// A new d is never applied immediately. It is held as pending and committed
// after the last data-rate enable of the current period. That way the
// transducer outputs always see whole periods.
//
// Ports:
//   i_clk           command/system clock (48 MHz)
//   i_reset         asynchronous, active-high reset
//   i_command       single-cycle command strobe
//   i_command_data  command word: [31:24] opcode, [7:0] argument
//   o_reply         single-cycle reply strobe, one cycle after i_command
//   o_reply_data    reply word: [31:24] opcode, [23:16] status,
//                   [15:8] active d, [7:0] pending d (active d if none pending)
//   o_data_ce       data-rate enable, one i_clk cycle wide
//   o_data_clk      divided square-wave data clock for the board pin (0 at d=0)
//   o_period_start  high on the enable that begins a carrier period
//   o_phase_step    high on the enable that begins a phase step
//   o_phase_index   phase-step index within the current period
//   o_div_log2      active d
//   o_mode_pending  a rate change is waiting for a period boundary

module rate_sel_timebase #(
  parameter int unsigned BASE_PERIOD_CYCLES = 1200,
  parameter int unsigned BASE_PHASE_CYCLES  = 64,
  parameter int unsigned MAX_DIV_LOG2       = 3,
  parameter int unsigned DEFAULT_DIV_LOG2   = 1,
  parameter logic [7:0]  CMD_SET            = 8'hD0,
  parameter logic [7:0]  CMD_QUERY          = 8'hD1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_command,
  input  logic [31:0] i_command_data,
  output logic        o_reply,
  output logic [31:0] o_reply_data,
  output logic        o_data_ce,
  output logic        o_data_clk,
  output logic        o_period_start,
  output logic        o_phase_step,
  output logic [7:0]  o_phase_index,
  output logic [2:0]  o_div_log2,
  output logic        o_mode_pending
);

  localparam int unsigned DivW = (MAX_DIV_LOG2 > 0) ? MAX_DIV_LOG2 : 1;
  localparam int unsigned PerW = ($clog2(BASE_PERIOD_CYCLES) > 0) ? $clog2(BASE_PERIOD_CYCLES) : 1;
  localparam int unsigned PhW  = ($clog2(BASE_PHASE_CYCLES) > 0) ? $clog2(BASE_PHASE_CYCLES) : 1;

  // State
  logic [2:0]      div_log2_q, div_log2_d;
  logic [2:0]      pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [PerW-1:0] period_cnt_q, period_cnt_d;
  logic [PhW-1:0]  phase_cnt_q, phase_cnt_d;
  logic [7:0]      phase_index_q, phase_index_d;
  logic            first_q, first_d;
  logic            data_ce_q, data_ce_d;
  logic            data_clk_q, data_clk_d;
  logic            reply_q, reply_d;
  logic [31:0]     reply_data_q, reply_data_d;

  // Derived terms
  logic [DivW-1:0] div_last;
  logic [DivW-1:0] half_next;
  logic [PerW-1:0] period_last;
  logic [PhW-1:0]  phase_last;
  logic            period_end;
  logic [7:0]      cmd_op;
  logic [7:0]      cmd_arg;
  logic [7:0]      status;
  logic            unused_cmd_bits;

  assign cmd_op          = i_command_data[31:24];
  assign cmd_arg         = i_command_data[7:0];
  assign unused_cmd_bits = ^i_command_data[23:8];

  // Terminal counts at the active rate
  always_comb begin
    div_last    = DivW'((32'd1 << div_log2_q) - 32'd1);
    period_last = PerW'((BASE_PERIOD_CYCLES >> div_log2_q) - 32'd1);
    phase_last  = PhW'((BASE_PHASE_CYCLES >> div_log2_q) - 32'd1);
  end

  // Last enable of the current carrier period: the only place d may change.
  assign period_end = data_ce_q && (period_cnt_q == period_last);

  always_comb begin
    div_log2_d    = div_log2_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    period_cnt_d  = period_cnt_q;
    phase_cnt_d   = phase_cnt_q;
    phase_index_d = phase_index_q;
    first_d       = first_q;
    reply_d       = 1'b0;
    reply_data_d  = reply_data_q;
    status        = 8'h00;
    half_next     = '0;

    // Divider. The enable is decoded from the count before it wraps, so it
    // lands in the cycle where div_cnt is back at 0.
    div_cnt_d = (div_cnt_q == div_last) ? '0 : div_cnt_q + DivW'(1);
    data_ce_d = (div_cnt_q == div_last);

    // Period and phase counters advance only on data-rate enables.
    if (data_ce_q) begin
      first_d = 1'b0;
      if (period_cnt_q == period_last) begin
        // The trailing partial phase step is dropped, not carried over.
        period_cnt_d  = '0;
        phase_cnt_d   = '0;
        phase_index_d = 8'd0;
      end else begin
        period_cnt_d = period_cnt_q + PerW'(1);
        if (phase_cnt_q == phase_last) begin
          phase_cnt_d   = '0;
          phase_index_d = phase_index_q + 8'd1;
        end else begin
          phase_cnt_d = phase_cnt_q + PhW'(1);
        end
      end
    end

    // Commit a pending rate after the last enable of the period. The
    // counters restart, so the first enable at the new rate opens a period.
    if (period_end && pend_valid_q) begin
      div_log2_d   = pend_q;
      div_cnt_d    = '0;
      period_cnt_d = '0;
      phase_cnt_d  = '0;
      first_d      = 1'b1;
      pend_valid_d = 1'b0;
    end

    // Square wave: low for the first half of the divided period, high for the
    // second. half_next is 0 when d is 0, which holds the pin low.
    half_next  = DivW'((32'd1 << div_log2_d) >> 1);
    data_clk_d = |(div_cnt_d & half_next);

    // Command decode. A request that arrives on the commit cycle becomes the
    // pending value for the following boundary.
    if (i_command) begin
      if (cmd_op == CMD_SET) begin
        reply_d = 1'b1;
        if (cmd_arg <= 8'(MAX_DIV_LOG2)) begin
          pend_d       = cmd_arg[2:0];
          pend_valid_d = 1'b1;
          status       = 8'h00;
        end else begin
          status = 8'h01;
        end
      end else if (cmd_op == CMD_QUERY) begin
        reply_d = 1'b1;
        status  = 8'h00;
      end
    end

    // The reply reports the state as it stands after this command.
    if (reply_d) begin
      reply_data_d = {cmd_op, status, 5'd0, div_log2_d, 5'd0,
                      pend_valid_d ? pend_d : div_log2_d};
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      div_log2_q    <= 3'(DEFAULT_DIV_LOG2);
      pend_q        <= 3'd0;
      pend_valid_q  <= 1'b0;
      div_cnt_q     <= '0;
      period_cnt_q  <= '0;
      phase_cnt_q   <= '0;
      phase_index_q <= 8'd0;
      first_q       <= 1'b1;
      data_ce_q     <= 1'b0;
      data_clk_q    <= 1'b0;
      reply_q       <= 1'b0;
      reply_data_q  <= 32'd0;
    end else begin
      div_log2_q    <= div_log2_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      div_cnt_q     <= div_cnt_d;
      period_cnt_q  <= period_cnt_d;
      phase_cnt_q   <= phase_cnt_d;
      phase_index_q <= phase_index_d;
      first_q       <= first_d;
      data_ce_q     <= data_ce_d;
      data_clk_q    <= data_clk_d;
      reply_q       <= reply_d;
      reply_data_q  <= reply_data_d;
    end
  end

  // Markers are qualified by the registered enable, so they share its cycle.
  assign o_period_start = data_ce_q && (first_q || (period_cnt_q == '0));
  assign o_phase_step   = data_ce_q && (phase_cnt_q == '0);
  assign o_phase_index  = phase_index_q;
  assign o_data_ce      = data_ce_q;
  assign o_data_clk     = data_clk_q;
  assign o_div_log2     = div_log2_q;
  assign o_mode_pending = pend_valid_q;
  assign o_reply        = reply_q;
  assign o_reply_data   = reply_data_q;

endmodule

// File: tb/tb_rate_sel_timebase.sv
module tb_rate_sel_timebase;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd;
  logic [31:0] cmd_data;
  logic        o_reply;
  logic [31:0] o_reply_data;
  logic        o_data_ce;
  logic        o_data_clk;
  logic        o_period_start;
  logic        o_phase_step;
  logic [7:0]  o_phase_index;
  logic [2:0]  o_div_log2;
  logic        o_mode_pending;

  always #10 clk = ~clk;

  rate_sel_timebase dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_command      (cmd),
    .i_command_data (cmd_data),
    .o_reply        (o_reply),
    .o_reply_data   (o_reply_data),
    .o_data_ce      (o_data_ce),
    .o_data_clk     (o_data_clk),
    .o_period_start (o_period_start),
    .o_phase_step   (o_phase_step),
    .o_phase_index  (o_phase_index),
    .o_div_log2     (o_div_log2),
    .o_mode_pending (o_mode_pending)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  // Results of the most recent wait_start call.
  int w_n, w_ce, w_hi, w_st, w_idx;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present one command word for a single cycle; returns on the reply cycle.
  task automatic send(input logic [31:0] w);
    cmd      = 1'b1;
    cmd_data = w;
    step(1);
    cmd      = 1'b0;
    cmd_data = 32'd0;
  endtask

  // Step until o_period_start, counting enables, data-clock-high cycles and
  // phase steps on the way. w_n stays -1 if the bound expires.
  task automatic wait_start(input int bound);
    bit done;
    done  = 1'b0;
    w_n   = -1;
    w_ce  = 0;
    w_hi  = 0;
    w_st  = 0;
    w_idx = -1;
    for (int i = 1; i <= bound && !done; i++) begin
      @(negedge clk);
      if (o_data_ce) w_ce++;
      if (o_data_clk) w_hi++;
      if (o_phase_step) w_st++;
      if (o_phase_step && !o_period_start) w_idx = int'(o_phase_index);
      if (o_period_start) begin
        w_n  = i;
        done = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd = 1'b0; cmd_data = 32'd0;
    step(3);
    n_cmp++; if (o_data_ce !== 1'b0) begin n_fail++; $display("FAIL rst_ce: got %b want 0", o_data_ce); end
    n_cmp++; if (o_data_clk !== 1'b0) begin n_fail++; $display("FAIL rst_clk: got %b want 0", o_data_clk); end
    n_cmp++; if (o_div_log2 !== 3'd1) begin n_fail++; $display("FAIL rst_div: got %0d want 1", o_div_log2); end
    n_cmp++; if (o_mode_pending !== 1'b0) begin n_fail++; $display("FAIL rst_pend: got %b want 0", o_mode_pending); end
    n_cmp++; if ({o_reply, o_period_start, o_phase_step} !== 3'b000) begin n_fail++; $display("FAIL rst_strobes: got %b want 000", {o_reply, o_period_start, o_phase_step}); end
    n_cmp++; if (o_reply_data !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", o_reply_data); end
    rst = 1'b0;
  endtask

  task automatic test_d1_timing;
    wait_start(50);
    n_cmp++; if (w_n !== 2) begin n_fail++; $display("FAIL d1_first_ce: got %0d want 2", w_n); end
    n_cmp++; if ({o_phase_step, o_phase_index} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL d1_first_step: got %b/%0d want 1/0", o_phase_step, o_phase_index); end
    n_cmp++; if (o_data_clk !== 1'b0) begin n_fail++; $display("FAIL d1_clk_lo: got %b want 0", o_data_clk); end
    step(1);
    n_cmp++; if ({o_data_ce, o_data_clk} !== 2'b01) begin n_fail++; $display("FAIL d1_clk_hi: got %b want 01", {o_data_ce, o_data_clk}); end
    wait_start(1300);
    n_cmp++; if (w_n !== 1199) begin n_fail++; $display("FAIL d1_period: got %0d want 1199", w_n); end
    n_cmp++; if (w_ce !== 600) begin n_fail++; $display("FAIL d1_ces: got %0d want 600", w_ce); end
    n_cmp++; if (w_hi !== 599) begin n_fail++; $display("FAIL d1_clk_hi_cnt: got %0d want 599", w_hi); end
    n_cmp++; if (w_st !== 19) begin n_fail++; $display("FAIL d1_steps: got %0d want 19", w_st); end
    n_cmp++; if (w_idx !== 18) begin n_fail++; $display("FAIL d1_last_idx: got %0d want 18", w_idx); end
    n_cmp++; if (o_phase_index !== 8'd0) begin n_fail++; $display("FAIL d1_idx_wrap: got %0d want 0", o_phase_index); end
  endtask

  task automatic test_set_invalid;
    step(1);
    send(32'hD000_0005);
    n_cmp++; if (o_reply !== 1'b1) begin n_fail++; $display("FAIL inval_strobe: got %b want 1", o_reply); end
    n_cmp++; if (o_reply_data !== 32'hD001_0101) begin n_fail++; $display("FAIL inval_reply: got %h want d0010101", o_reply_data); end
    n_cmp++; if (o_mode_pending !== 1'b0) begin n_fail++; $display("FAIL inval_pend: got %b want 0", o_mode_pending); end
    step(1);
    n_cmp++; if (o_reply !== 1'b0) begin n_fail++; $display("FAIL inval_one_cycle: got %b want 0", o_reply); end
  endtask

  task automatic test_set_deferred;
    send(32'hD000_0003);
    n_cmp++; if (o_reply_data !== 32'hD000_0103) begin n_fail++; $display("FAIL set3_reply: got %h want d0000103", o_reply_data); end
    n_cmp++; if (o_mode_pending !== 1'b1) begin n_fail++; $display("FAIL set3_pend: got %b want 1", o_mode_pending); end
    step(1194);
    n_cmp++; if ({o_data_ce, o_mode_pending, o_div_log2} !== {2'b11, 3'd1}) begin n_fail++; $display("FAIL set3_last_ce: got %b/%b/%0d want 1/1/1", o_data_ce, o_mode_pending, o_div_log2); end
    step(1);
    n_cmp++; if ({o_mode_pending, o_div_log2} !== {1'b0, 3'd3}) begin n_fail++; $display("FAIL set3_switch: got %b/%0d want 0/3", o_mode_pending, o_div_log2); end
    wait_start(50);
    n_cmp++; if (w_n !== 8) begin n_fail++; $display("FAIL set3_first_ce: got %0d want 8", w_n); end
    n_cmp++; if ({o_phase_step, o_phase_index} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL set3_first_step: got %b/%0d want 1/0", o_phase_step, o_phase_index); end
    wait_start(1300);
    n_cmp++; if (w_n !== 1200) begin n_fail++; $display("FAIL d3_period: got %0d want 1200", w_n); end
    n_cmp++; if (w_ce !== 150) begin n_fail++; $display("FAIL d3_ces: got %0d want 150", w_ce); end
    n_cmp++; if (w_hi !== 600) begin n_fail++; $display("FAIL d3_clk_hi_cnt: got %0d want 600", w_hi); end
    n_cmp++; if (w_st !== 19) begin n_fail++; $display("FAIL d3_steps: got %0d want 19", w_st); end
  endtask

  task automatic test_query_d0;
    step(2);
    send(32'hD000_0000);
    n_cmp++; if (o_reply_data !== 32'hD000_0300) begin n_fail++; $display("FAIL set0_reply: got %h want d0000300", o_reply_data); end
    send(32'hD100_0000);
    n_cmp++; if (o_reply_data !== 32'hD100_0300) begin n_fail++; $display("FAIL query_reply: got %h want d1000300", o_reply_data); end
    n_cmp++; if ({o_mode_pending, o_div_log2} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL query_state: got %b/%0d want 1/3", o_mode_pending, o_div_log2); end
    wait_start(1300);
    n_cmp++; if (w_n !== 1190) begin n_fail++; $display("FAIL set0_boundary: got %0d want 1190", w_n); end
    n_cmp++; if ({o_mode_pending, o_div_log2} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL set0_state: got %b/%0d want 0/0", o_mode_pending, o_div_log2); end
    wait_start(1300);
    n_cmp++; if (w_n !== 1200) begin n_fail++; $display("FAIL d0_period: got %0d want 1200", w_n); end
    n_cmp++; if (w_ce !== 1200) begin n_fail++; $display("FAIL d0_ces: got %0d want 1200", w_ce); end
    n_cmp++; if (w_hi !== 0) begin n_fail++; $display("FAIL d0_clk_held: got %0d want 0", w_hi); end
    n_cmp++; if (w_idx !== 18) begin n_fail++; $display("FAIL d0_last_idx: got %0d want 18", w_idx); end
  endtask

  task automatic test_switch_collision;
    step(5);
    send(32'hD000_0003);
    n_cmp++; if (o_reply_data !== 32'hD000_0003) begin n_fail++; $display("FAIL coll_set3: got %h want d0000003", o_reply_data); end
    step(1193);
    n_cmp++; if ({o_data_ce, o_mode_pending, o_div_log2} !== {2'b11, 3'd0}) begin n_fail++; $display("FAIL coll_last_ce: got %b/%b/%0d want 1/1/0", o_data_ce, o_mode_pending, o_div_log2); end
    send(32'hD000_0002);
    n_cmp++; if (o_reply_data !== 32'hD000_0302) begin n_fail++; $display("FAIL coll_reply: got %h want d0000302", o_reply_data); end
    n_cmp++; if ({o_mode_pending, o_div_log2} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL coll_state: got %b/%0d want 1/3", o_mode_pending, o_div_log2); end
    n_cmp++; if ({o_period_start, o_phase_index} !== {1'b1, 8'd0}) begin n_fail++; $display("FAIL coll_start: got %b/%0d want 1/0", o_period_start, o_phase_index); end
    wait_start(1300);
    n_cmp++; if (w_n !== 1197) begin n_fail++; $display("FAIL coll_d3_period: got %0d want 1197", w_n); end
    n_cmp++; if (w_ce !== 150) begin n_fail++; $display("FAIL coll_d3_ces: got %0d want 150", w_ce); end
    n_cmp++; if ({o_mode_pending, o_div_log2} !== {1'b0, 3'd2}) begin n_fail++; $display("FAIL coll_d2_state: got %b/%0d want 0/2", o_mode_pending, o_div_log2); end
    wait_start(1300);
    n_cmp++; if (w_n !== 1200) begin n_fail++; $display("FAIL d2_period: got %0d want 1200", w_n); end
    n_cmp++; if (w_ce !== 300) begin n_fail++; $display("FAIL d2_ces: got %0d want 300", w_ce); end
    n_cmp++; if (w_hi !== 600) begin n_fail++; $display("FAIL d2_clk_hi_cnt: got %0d want 600", w_hi); end
  endtask

  task automatic test_reset_mid;
    send(32'hD000_0001);
    n_cmp++; if (o_reply_data !== 32'hD000_0201) begin n_fail++; $display("FAIL rm_set1: got %h want d0000201", o_reply_data); end
    step(201);
    n_cmp++; if ({o_data_clk, o_phase_index} !== {1'b1, 8'd3}) begin n_fail++; $display("FAIL rm_before: got %b/%0d want 1/3", o_data_clk, o_phase_index); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({o_data_clk, o_phase_index} !== {1'b0, 8'd0}) begin n_fail++; $display("FAIL rm_async_clr: got %b/%0d want 0/0", o_data_clk, o_phase_index); end
    n_cmp++; if ({o_mode_pending, o_div_log2} !== {1'b0, 3'd1}) begin n_fail++; $display("FAIL rm_async_state: got %b/%0d want 0/1", o_mode_pending, o_div_log2); end
    n_cmp++; if (o_reply_data !== 32'd0) begin n_fail++; $display("FAIL rm_rdata: got %h want 0", o_reply_data); end
    step(3);
    rst = 1'b0;
    wait_start(50);
    n_cmp++; if (w_n !== 2) begin n_fail++; $display("FAIL rm_first_ce: got %0d want 2", w_n); end
    n_cmp++; if ({o_mode_pending, o_div_log2, o_phase_index} !== {1'b0, 3'd1, 8'd0}) begin n_fail++; $display("FAIL rm_after: got %b/%0d/%0d want 0/1/0", o_mode_pending, o_div_log2, o_phase_index); end
  endtask

  task automatic test_unknown_opcode;
    send(32'h4200_0003);
    n_cmp++; if (o_reply !== 1'b0) begin n_fail++; $display("FAIL unk_no_reply: got %b want 0", o_reply); end
    n_cmp++; if (o_mode_pending !== 1'b0) begin n_fail++; $display("FAIL unk_pend: got %b want 0", o_mode_pending); end
    send(32'hD100_0000);
    n_cmp++; if ({o_reply, o_reply_data} !== {1'b1, 32'hD100_0101}) begin n_fail++; $display("FAIL unk_query: got %b/%h want 1/d1000101", o_reply, o_reply_data); end
  endtask

  initial begin
    test_reset();
    test_d1_timing();
    test_set_invalid();
    test_set_deferred();
    test_query_d0();
    test_switch_collision();
    test_reset_mid();
    test_unknown_opcode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
